// File: rtl/uart_rx_sampler.sv
// UART receive front end: line synchroniser, mid-bit 2-of-3 majority sampler and
// 5..8 bit deframer feeding a single-word valid/ready holding register.
module uart_rx_sampler #(
  parameter int DIV_WIDTH = 16,
  parameter int DIV_MIN   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_en_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic [1:0]           cfg_bits_i,
  input  logic                 cfg_parity_en_i,
  input  logic [1:0]           cfg_parity_sel_i,
  input  logic                 cfg_stop_bits_i,
  input  logic                 rx_i,
  output logic [7:0]           rx_data_o,
  output logic                 rx_perr_o,
  output logic                 rx_ferr_o,
  output logic                 rx_brk_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 overrun_o,
  output logic                 busy_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BRKWAIT} state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_FLOOR = DIV_WIDTH'(DIV_MIN);
  localparam logic [DIV_WIDTH-1:0] ONE       = DIV_WIDTH'(1);

  state_t               state, state_n;
  logic                 sync1, rxs, rxs_prev, fall;
  logic [DIV_WIDTH-1:0] cnt, div_q, half, div_eff;
  logic                 at_s0, at_s1, at_dec, at_end;
  logic [1:0]           samp;
  logic                 maj;
  logic [1:0]           bits_q, par_sel_q;
  logic                 par_en_q, stop2_q;
  logic [2:0]           bit_idx, last_idx;
  logic [7:0]           shreg;
  logic                 perr_f, ferr_f, zero_f, par_exp;
  logic                 start_frame, done;
  logic                 brk_c, ferr_c, perr_c;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1    <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync1    <= rx_i;
      rxs      <= sync1;
      rxs_prev <= rxs;
    end
  end

  assign fall    = rxs_prev & ~rxs;
  assign div_eff = (cfg_div_i < DIV_FLOOR) ? DIV_FLOOR : cfg_div_i;
  assign half    = div_q >> 1;
  assign at_s0   = (cnt == half - ONE);
  assign at_s1   = (cnt == half);
  assign at_dec  = (cnt == half + ONE);
  assign at_end  = (cnt == div_q - ONE);
  assign maj     = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);

  assign last_idx = {1'b0, bits_q} + 3'd4;
  // Mark/space give the constant in sel[0]; even/odd fold sel[0] in as an inversion.
  assign par_exp  = par_sel_q[1] ? par_sel_q[0] : ((^shreg) ^ par_sel_q[0]);

  // The final stop decision happens in the completion cycle, so it is folded in here.
  assign brk_c  = zero_f & ~maj;
  assign ferr_c = ferr_f | ~maj;
  assign perr_c = perr_f & ~brk_c;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n     = state;
    start_frame = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: if (fall) begin
        state_n     = START;
        start_frame = 1'b1;
      end
      START: begin
        if (at_dec && maj) state_n = IDLE;
        else if (at_end)   state_n = DATA;
      end
      DATA: if (at_end && bit_idx == last_idx) state_n = par_en_q ? PARITY : STOP1;
      PARITY: if (at_end) state_n = STOP1;
      STOP1: begin
        if (stop2_q) begin
          if (at_end) state_n = STOP2;
        end else if (at_dec) begin
          done    = 1'b1;
          state_n = brk_c ? BRKWAIT : IDLE;
        end
      end
      STOP2: if (at_dec) begin
        done    = 1'b1;
        state_n = brk_c ? BRKWAIT : IDLE;
      end
      BRKWAIT: if (rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (!cfg_en_i) begin
      state_n     = IDLE;
      start_frame = 1'b0;
      done        = 1'b0;
    end
  end

  // The detect cycle itself counts as cnt=0 of the start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      samp  <= 2'b00;
    end else begin
      state <= state_n;
      if (start_frame)                                 cnt <= ONE;
      else if (state == IDLE || at_end || state_n != state) cnt <= '0;
      else                                             cnt <= cnt + ONE;
      if (at_s0) samp[0] <= rxs;
      if (at_s1) samp[1] <= rxs;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q     <= DIV_FLOOR;
      bits_q    <= 2'b00;
      par_en_q  <= 1'b0;
      par_sel_q <= 2'b00;
      stop2_q   <= 1'b0;
      shreg     <= 8'h00;
      bit_idx   <= 3'd0;
      perr_f    <= 1'b0;
      ferr_f    <= 1'b0;
      zero_f    <= 1'b0;
    end else if (start_frame) begin
      div_q     <= div_eff;
      bits_q    <= cfg_bits_i;
      par_en_q  <= cfg_parity_en_i;
      par_sel_q <= cfg_parity_sel_i;
      stop2_q   <= cfg_stop_bits_i;
      shreg     <= 8'h00;
      bit_idx   <= 3'd0;
      perr_f    <= 1'b0;
      ferr_f    <= 1'b0;
      zero_f    <= 1'b1;
    end else begin
      case (state)
        DATA: begin
          if (at_dec) begin
            shreg[bit_idx] <= maj;
            if (maj) zero_f <= 1'b0;
          end
          if (at_end) bit_idx <= bit_idx + 3'd1;
        end
        PARITY: if (at_dec) begin
          if (maj != par_exp) perr_f <= 1'b1;
          if (maj) zero_f <= 1'b0;
        end
        STOP1: if (at_dec) begin
          if (maj) zero_f <= 1'b0;
          else     ferr_f <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_data_o  <= 8'h00;
      rx_perr_o  <= 1'b0;
      rx_ferr_o  <= 1'b0;
      rx_brk_o   <= 1'b0;
      rx_valid_o <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (done && (!rx_valid_o || rx_ready_i)) begin
        rx_data_o  <= shreg;
        rx_perr_o  <= perr_c;
        rx_ferr_o  <= ferr_c;
        rx_brk_o   <= brk_c;
        rx_valid_o <= 1'b1;
      end else begin
        if (done) overrun_o <= 1'b1;
        if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
      end
    end
  end

  assign busy_o = (state != IDLE);

endmodule
